// File: rtl/conv_neuron_mac.sv
// Pipelined convolution neuron: TAPS-wide signed dot product accumulated over BEATS beats, then shifted and saturated.
// Optional build macro CONV_NEURON_RELU_EN clamps negative results to zero after saturation.
module conv_neuron_mac #(
    parameter int unsigned TAPS  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned BEATS = 1,
    parameter int unsigned OW    = 8,
    parameter int unsigned SHIFT = 0,
    localparam int unsigned KIW  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kernel_we,
    input  logic [KIW-1:0]       kernel_idx,
    input  logic [TAPS*DW-1:0]   kernel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TAPS*DW-1:0]   pixels,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        convResult,
    output logic                 sat
);

    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned ACCW = PW + $clog2(TAPS * BEATS);
    localparam int unsigned ROWW = TAPS * DW;

    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [ROWW-1:0]        kern_q [BEATS];
    logic [ROWW-1:0]        kern_d [BEATS];
    logic [KIW-1:0]         bc_q, bc_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_last_q, s1_last_d;
    logic signed [PW-1:0]   prod_q [TAPS];
    logic signed [PW-1:0]   prod_d [TAPS];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   out_valid_q, out_valid_d;
    logic [OW-1:0]          result_q, result_d;
    logic                   sat_q, sat_d;

    logic                   stall;
    logic                   accept;
    logic                   last_beat;
    logic [ROWW-1:0]        kern_row;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] total;
    logic signed [ACCW-1:0] shifted;
    logic [OW-1:0]          clipped;
    logic [OW-1:0]          final_val;
    logic                   clip;

    // Handshake: a held result freezes the whole pipeline
    always_comb begin
        stall    = out_valid_q && !out_ready;
        accept   = in_valid && !stall;
        in_ready = !stall;
    end

    // Kernel store; out-of-range indices match no entry and are dropped
    always_comb begin
        kern_d = kern_q;
        if (kernel_we) begin
            for (int b = 0; b < BEATS; b++) begin
                if (kernel_idx == KIW'(b)) begin
                    kern_d[b] = kernel;
                end
            end
        end
    end

    // Stage 1: beat counter and per-tap products against the current entry
    always_comb begin
        kern_row   = '0;
        bc_d       = bc_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        prod_d     = prod_q;
        for (int b = 0; b < BEATS; b++) begin
            if (bc_q == KIW'(b)) begin
                kern_row = kern_q[b];
            end
        end
        last_beat = (bc_q == KIW'(BEATS - 1));
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_last_d = last_beat;
                bc_d      = last_beat ? '0 : bc_q + KIW'(1);
                for (int i = 0; i < TAPS; i++) begin
                    prod_d[i] = PW'($signed(pixels[i*DW +: DW])) *
                                PW'($signed(kern_row[i*DW +: DW]));
                end
            end
        end
    end

    // Stage 2: reduce, accumulate, then shift and saturate on the final beat
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum = sum + ACCW'(prod_q[i]);
        end
        total   = acc_q + sum;
        shifted = total >>> SHIFT;
        clip    = 1'b0;
        if (shifted > SAT_MAX) begin
            clipped = {1'b0, {(OW-1){1'b1}}};
            clip    = 1'b1;
        end else if (shifted < SAT_MIN) begin
            clipped = {1'b1, {(OW-1){1'b0}}};
            clip    = 1'b1;
        end else begin
            clipped = OW'(shifted);
        end
`ifdef CONV_NEURON_RELU_EN
        final_val = clipped[OW-1] ? '0 : clipped;
`else
        final_val = clipped;
`endif

        acc_d       = acc_q;
        result_d    = result_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q && !out_ready;
        if (!stall && s1_valid_q) begin
            if (s1_last_q) begin
                acc_d       = '0;
                result_d    = final_val;
                sat_d       = clip;
                out_valid_d = 1'b1;
            end else begin
                acc_d = total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BEATS; b++) begin
                kern_q[b] <= '0;
            end
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= '0;
            end
            bc_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            kern_q      <= kern_d;
            prod_q      <= prod_d;
            bc_q        <= bc_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign convResult = result_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_conv_neuron_mac.sv
// Directed bench for conv_neuron_mac: single-beat and three-beat instances, hand-computed results.
module tb_conv_neuron_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        k1_we;
    logic [0:0]  k1_idx;
    logic [31:0] k1_kernel;
    logic        in1_valid, in1_ready;
    logic [31:0] px1;
    logic        out1_valid, out1_ready;
    logic [7:0]  res1;
    logic        sat1;

    logic        k3_we;
    logic [1:0]  k3_idx;
    logic [31:0] k3_kernel;
    logic        in3_valid, in3_ready;
    logic [31:0] px3;
    logic        out3_valid, out3_ready;
    logic [7:0]  res3;
    logic        sat3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_neg_small;
    logic [7:0] exp_neg_sat;

    conv_neuron_mac #(.TAPS(4), .DW(8), .BEATS(1), .OW(8), .SHIFT(0)) u_dut1 (
        .clk(clk), .rst(rst), .kernel_we(k1_we), .kernel_idx(k1_idx), .kernel(k1_kernel),
        .in_valid(in1_valid), .in_ready(in1_ready), .pixels(px1),
        .out_valid(out1_valid), .out_ready(out1_ready), .convResult(res1), .sat(sat1)
    );

    conv_neuron_mac #(.TAPS(4), .DW(8), .BEATS(3), .OW(8), .SHIFT(0)) u_dut3 (
        .clk(clk), .rst(rst), .kernel_we(k3_we), .kernel_idx(k3_idx), .kernel(k3_kernel),
        .in_valid(in3_valid), .in_ready(in3_ready), .pixels(px3),
        .out_valid(out3_valid), .out_ready(out3_ready), .convResult(res3), .sat(sat3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_k1(input logic [31:0] k);
        k1_we = 1'b1; k1_idx = 1'b0; k1_kernel = k;
        tick();
        k1_we = 1'b0;
    endtask

    // Entries 0..2 get all-ones taps; the write to index 3 is out of range
    task automatic load_k3();
        for (int i = 0; i < 4; i++) begin
            k3_we = 1'b1; k3_idx = 2'(i);
            k3_kernel = (i == 3) ? 32'h7f7f7f7f : 32'h01010101;
            tick();
        end
        k3_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        k1_we = 0; k1_idx = 0; k1_kernel = 0; in1_valid = 0; px1 = 0; out1_ready = 1;
        k3_we = 0; k3_idx = 0; k3_kernel = 0; in3_valid = 0; px3 = 0; out3_ready = 1;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({out1_valid, res1, sat1, in1_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h expected %h", {out1_valid, res1, sat1, in1_ready}, {1'b0, 8'h00, 1'b0, 1'b1});
        end
        n_checks++;
        if ({out3_valid, res3, sat3, in3_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_dut3: got %h expected %h", {out3_valid, res3, sat3, in3_ready}, {1'b0, 8'h00, 1'b0, 1'b1});
        end
        // Kernel entries come out of reset as zero
        px1 = 32'h7f7f7f7f; in1_valid = 1'b1;
        tick();
        in1_valid = 1'b0;
        tick();
        n_checks++;
        if ({out1_valid, res1, sat1} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_zero_kernel: got %h expected %h", {out1_valid, res1, sat1}, {1'b1, 8'h00, 1'b0});
        end
    endtask

    task automatic test_basic();
        logic [31:0] pv [4];
        logic [7:0]  ev [4];
        pv = '{32'h01ffff01, 32'hff0101ff, 32'h01010101, 32'hffffffff};
        ev = '{8'h04, 8'hfc, 8'h00, 8'h00};
        load_k1(32'h01ffff01);
        for (int i = 0; i < 4; i++) begin
            px1 = pv[i]; in1_valid = 1'b1;
            tick();
            in1_valid = 1'b0;
            tick();
            n_checks++;
            if ({out1_valid, res1, sat1} !== {1'b1, ev[i], 1'b0}) begin
                n_fail++;
                $display("FAIL basic_%0d: got %h expected %h", i, {out1_valid, res1, sat1}, {1'b1, ev[i], 1'b0});
            end
        end
    endtask

    task automatic test_kernel_reload();
        // The beat accepted alongside the write still uses the old kernel
        px1 = 32'h01ffff01; in1_valid = 1'b1;
        k1_we = 1'b1; k1_idx = 1'b0; k1_kernel = 32'h05fbfb05;
        tick();
        k1_we = 1'b0; in1_valid = 1'b0;
        tick();
        n_checks++;
        if ({out1_valid, res1} !== {1'b1, 8'h04}) begin
            n_fail++;
            $display("FAIL reload_same_cycle: got %h expected %h", {out1_valid, res1}, {1'b1, 8'h04});
        end
        // Back-to-back: one result per cycle
        px1 = 32'h01ffff01; in1_valid = 1'b1;
        tick();
        px1 = 32'hff0101ff;
        tick();
        n_checks++;
        if ({out1_valid, res1, sat1} !== {1'b1, 8'h14, 1'b0}) begin
            n_fail++;
            $display("FAIL reload_a: got %h expected %h", {out1_valid, res1, sat1}, {1'b1, 8'h14, 1'b0});
        end
        px1 = 32'hffffffff;
        tick();
        n_checks++;
        if ({out1_valid, res1, sat1} !== {1'b1, exp_neg_small, 1'b0}) begin
            n_fail++;
            $display("FAIL reload_b: got %h expected %h", {out1_valid, res1, sat1}, {1'b1, exp_neg_small, 1'b0});
        end
        in1_valid = 1'b0;
        tick();
        n_checks++;
        if ({out1_valid, res1, sat1} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reload_c: got %h expected %h", {out1_valid, res1, sat1}, {1'b1, 8'h00, 1'b0});
        end
        tick();
        n_checks++;
        if (out1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_drain: got %b expected 0", out1_valid);
        end
    endtask

    task automatic test_saturation();
        load_k1(32'h7f7f7f7f);
        px1 = 32'h7f7f7f7f; in1_valid = 1'b1;
        tick();
        in1_valid = 1'b0;
        tick();
        n_checks++;
        if ({out1_valid, res1, sat1} !== {1'b1, 8'h7f, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_pos: got %h expected %h", {out1_valid, res1, sat1}, {1'b1, 8'h7f, 1'b1});
        end
        load_k1(32'h80808080);
        px1 = 32'h7f7f7f7f; in1_valid = 1'b1;
        tick();
        in1_valid = 1'b0;
        tick();
        n_checks++;
        if ({out1_valid, res1, sat1} !== {1'b1, exp_neg_sat, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_neg: got %h expected %h", {out1_valid, res1, sat1}, {1'b1, exp_neg_sat, 1'b1});
        end
    endtask

    task automatic test_backpressure();
        load_k1(32'h05fbfb05);
        out1_ready = 1'b0;
        px1 = 32'h01ffff01; in1_valid = 1'b1;
        tick();
        n_checks++;
        if (in1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_before: got %b expected 1", in1_ready);
        end
        px1 = 32'hff0101ff;
        tick();
        px1 = 32'hffffffff;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({in1_ready, out1_valid, res1} !== {1'b0, 1'b1, 8'h14}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got %h expected %h", i, {in1_ready, out1_valid, res1}, {1'b0, 1'b1, 8'h14});
            end
            if (i < 4) tick();
        end
        out1_ready = 1'b1;
        #1;
        n_checks++;
        if (in1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b expected 1", in1_ready);
        end
        tick();
        in1_valid = 1'b0;
        n_checks++;
        if ({out1_valid, res1} !== {1'b1, exp_neg_small}) begin
            n_fail++;
            $display("FAIL bp_second: got %h expected %h", {out1_valid, res1}, {1'b1, exp_neg_small});
        end
        tick();
        n_checks++;
        if ({out1_valid, res1} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL bp_third: got %h expected %h", {out1_valid, res1}, {1'b1, 8'h00});
        end
        tick();
        n_checks++;
        if (out1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %b expected 0", out1_valid);
        end
    endtask

    task automatic test_multi_beat();
        logic [31:0] pv [6];
        logic        ev_valid [8];
        pv = '{32'h01010101, 32'h02020202, 32'hffffffff,
               32'h02020202, 32'h02020202, 32'h01010101};
        ev_valid = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        load_k3();
        for (int i = 0; i < 8; i++) begin
            in3_valid = (i < 6);
            px3 = (i < 6) ? pv[i] : 32'h0;
            tick();
            n_checks++;
            if (out3_valid !== ev_valid[i]) begin
                n_fail++;
                $display("FAIL multi_valid_%0d: got %b expected %b", i, out3_valid, ev_valid[i]);
            end
            if (i == 3) begin
                n_checks++;
                if ({res3, sat3} !== {8'h08, 1'b0}) begin
                    n_fail++;
                    $display("FAIL multi_group1: got %h expected %h", {res3, sat3}, {8'h08, 1'b0});
                end
            end
            if (i == 6) begin
                n_checks++;
                if ({res3, sat3} !== {8'h14, 1'b0}) begin
                    n_fail++;
                    $display("FAIL multi_group2: got %h expected %h", {res3, sat3}, {8'h14, 1'b0});
                end
            end
        end
        in3_valid = 1'b0;
    endtask

    task automatic test_reset_mid_group();
        px3 = 32'h7f7f7f7f; in3_valid = 1'b1;
        tick();
        in3_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({out3_valid, in3_ready} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_state: got %b expected %b", {out3_valid, in3_ready}, 2'b01);
        end
        load_k3();
        in3_valid = 1'b1;
        px3 = 32'h01010101; tick();
        px3 = 32'h02020202; tick();
        px3 = 32'hffffffff; tick();
        in3_valid = 1'b0;
        n_checks++;
        if (out3_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_early: got %b expected 0", out3_valid);
        end
        tick();
        n_checks++;
        if ({out3_valid, res3, sat3} !== {1'b1, 8'h08, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_result: got %h expected %h", {out3_valid, res3, sat3}, {1'b1, 8'h08, 1'b0});
        end
    endtask

    initial begin
`ifdef CONV_NEURON_RELU_EN
        exp_neg_small = 8'h00;
        exp_neg_sat   = 8'h00;
`else
        exp_neg_small = 8'hec;
        exp_neg_sat   = 8'h80;
`endif
        test_reset();
        test_basic();
        test_kernel_reload();
        test_saturation();
        test_backpressure();
        test_multi_beat();
        test_reset_mid_group();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_neuron_mac.md
# conv_neuron_mac

Parametrised, pipelined successor to the single-cycle convolution neuron. Computes a signed dot product of `TAPS` pixels against a stored kernel, accumulates over `BEATS` input beats so larger kernels can be streamed through a narrow datapath, then shifts and saturates to `OW` bits. It sits between the line-buffer/pixel streamer and the activation/pooling stage, with valid/ready handshakes on both sides.

## Interface
- `TAPS`, 4, pixels/weights per beat
- `DW`, 8, signed pixel and weight width
- `BEATS`, 1, beats accumulated per result (≥1)
- `OW`, 8, signed result width
- `SHIFT`, 0, arithmetic right shift applied before saturation
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `kernel_we`  in  1  write kernel entry
- `kernel_idx`  in  max(1,$clog2(BEATS))  kernel entry (beat) index
- `kernel`  in  TAPS*DW  kernel taps; tap i = `kernel[i*DW +: DW]`
- `in_valid`  in  1  pixel beat valid
- `in_ready`  out  1  block can accept a beat
- `pixels`  in  TAPS*DW  pixel taps; tap i = `pixels[i*DW +: DW]`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `convResult`  out  OW  signed saturated result
- `sat`  out  1  result was clipped; qualified by `out_valid`

## Operation
- Kernel store: `BEATS` entries of TAPS×DW. Write on `kernel_we` takes effect at the next edge. A write with `kernel_idx ≥ BEATS` is ignored.
- Beat accept: `in_valid && in_ready`. The beat counter `bc` selects kernel entry `bc`. The counter increments per accept and wraps to 0 after `BEATS-1`. The final beat of a group is the one accepted with `bc == BEATS-1`.
- Stage 1 registers TAPS signed products, DW×DW → 2·DW bits, using the kernel value present in the accept cycle. A same-cycle write to that entry is not seen by that beat.
- Stage 2:
  - Adder-tree sum of the products, added into the accumulator.
  - Accumulator width is ACCW = 2·DW + $clog2(TAPS·BEATS), and it never overflows.
  - On the final beat, result = (acc + sum) >>> SHIFT, floor rounding. This is saturated to [−2^(OW−1), 2^(OW−1)−1] and loaded into `convResult`.
  - On that same edge, `sat` = clipped, `out_valid` = 1, and the accumulator clears to 0.
- Backpressure: stall = `out_valid && !out_ready`. While stalled, every pipeline register, the accumulator and `bc` hold.
- `in_ready` = !stall, which makes it combinational from `out_ready`.
- `out_valid` clears when `out_ready` is high, unless a new result loads on the same edge.

## Timing
- Reset values:
  - `out_valid` = 0, `convResult` = 0, `sat` = 0
  - accumulator = 0, `bc` = 0, stage-1 valid = 0
  - all kernel entries = 0
  - `in_ready` = 1 after reset.
- Latency: final beat accepted in cycle t → `out_valid`/`convResult` visible in cycle t+2.
- Throughput: one beat per cycle with no stall. With BEATS=1, one result per cycle.
- Simultaneous result pop and new result load: the new result replaces the old one and `out_valid` stays 1.
- `rst` asserted mid-group discards partial accumulation and in-flight beats. The next accepted beat is beat 0.

## Configuration
- `CONV_NEURON_RELU_EN` defined: after saturation, negative results are forced to 0.
  - `sat` still reports saturation from before ReLU.
  - A result clipped to the negative limit outputs 0 with `sat`=1.
- Undefined: signed output unchanged, and no ReLU logic is generated.

## Test plan
- **Basic dot product (BEATS=1, OW=8, SHIFT=0).** Kernel entry 0 = 32'h01ffff01, then `out_ready`=1. Pixels and required `convResult`, each 2 cycles after accept, `sat`=0:
  - 32'h01ffff01 → 8'h04
  - 32'hff0101ff → 8'hfc
  - 32'h01010101 → 8'h00
  - 32'hffffffff → 8'h00
- **Kernel reload.** Kernel = 32'h05fbfb05. Pixels and required results:
  - 32'h01ffff01 → 8'h14
  - 32'hff0101ff → 8'hec
  - 32'hffffffff → 8'h00
  - Back-to-back beats give one result per cycle.
- **Saturation.**
  - Kernel 32'h7f7f7f7f × pixels 32'h7f7f7f7f → 8'h7f, `sat`=1.
  - Kernel 32'h80808080 × pixels 32'h7f7f7f7f → 8'h80, `sat`=1.
- **Multi-beat accumulation (BEATS=3).** Kernels 32'h01010101 ×3; pixels 32'h01010101, 32'h02020202, 32'hffffffff.
  - `out_valid` is asserted only after the 3rd beat, with result 8'h08.
  - A fourth beat starts a new group.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles while a result is valid.
  - `in_ready`=0 and `convResult` stays stable during the hold.
  - On release, no beat is lost or duplicated and the result order is preserved.
- **Reset and ReLU.**
  - Assert `rst` after beat 1 of 3: `out_valid`=0, and the next full group produces the correct result.
  - With `CONV_NEURON_RELU_EN`, the kernel 32'h05fbfb05 / pixels 32'hff0101ff case gives 8'h00.
